// File: rtl/pad_array_reader.sv
// pad_array_reader: polls CHANNELS serial NES/SNES pads over a shared latch/clock pair
module pad_array_reader #(
    parameter int BOARD    = 50_000_000,
    parameter int SAMPLE   = 1000,
    parameter int LATCH    = 12,
    parameter int CLK      = 6,
    parameter int CHANNELS = 2,
    parameter int BITS     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     poll_req,
    output logic                     pad_latch,
    output logic                     pad_clk,
    input  logic [CHANNELS-1:0]      pad_data,
    output logic [CHANNELS*BITS-1:0] buttons,
    output logic [CHANNELS*BITS-1:0] pressed,
    output logic [CHANNELS*BITS-1:0] released,
    output logic [CHANNELS-1:0]      present,
    output logic                     ready
);
    localparam int SAMPLE_TICKS = BOARD / SAMPLE;
    localparam int LATCH_TICKS  = (BOARD / 1_000_000) * LATCH;
    localparam int HALF_TICKS   = ((BOARD / 1_000_000) * CLK) / 2;
    localparam int TMAX         = LATCH_TICKS > HALF_TICKS ? LATCH_TICKS : HALF_TICKS;
    localparam int PW           = $clog2(SAMPLE_TICKS + 1);
    localparam int TW           = $clog2(TMAX + 1);
    localparam int IW           = $clog2(BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SETTLE, S_SAMPLE, S_CLK_HI, S_CLK_LO, S_DONE
    } state_t;

    state_t                        state, state_n;
    logic [PW-1:0]                 period;
    logic [TW-1:0]                 tmr;
    logic [IW-1:0]                 idx;
    logic                          pending, wrap, half_done;
    logic [CHANNELS-1:0]           sync1, sync2, det;
    logic [CHANNELS-1:0][BITS:0]   shift;
    logic [CHANNELS*BITS-1:0]      new_btn;

    assign wrap      = enable && period == PW'(SAMPLE_TICKS - 1);
    assign half_done = tmr == TW'(HALF_TICKS - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period  <= '0;
            pending <= 1'b0;
        end else begin
            period  <= (poll_req || !enable || wrap) ? '0 : period + 1'b1;
            pending <= poll_req | wrap | (pending & (state != S_IDLE));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_n;
            tmr   <= (state_n != state) ? '0 : tmr + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = pending ? S_LATCH : S_IDLE;
            S_LATCH:  state_n = tmr == TW'(LATCH_TICKS - 1) ? S_SETTLE : S_LATCH;
            S_SETTLE: state_n = half_done ? S_SAMPLE : S_SETTLE;
            S_SAMPLE: state_n = idx == IW'(BITS) ? S_DONE : S_CLK_HI;
            S_CLK_HI: state_n = half_done ? S_CLK_LO : S_CLK_HI;
            S_CLK_LO: state_n = half_done ? S_SAMPLE : S_CLK_LO;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        pad_latch = state == S_LATCH;
        pad_clk   = state == S_CLK_HI;
    end

    // The trailing sample is the presence bit; stored inverted, so 1 means the line read ground
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign det[c]                  = shift[c][BITS];
        assign new_btn[c*BITS +: BITS] = det[c] ? shift[c][BITS-1:0] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            idx      <= '0;
            shift    <= '0;
            buttons  <= '0;
            pressed  <= '0;
            released <= '0;
            present  <= '0;
            ready    <= 1'b0;
        end else begin
            sync1    <= pad_data;
            sync2    <= sync1;
            idx      <= state == S_LATCH ? '0 :
                        (state == S_CLK_LO && half_done) ? idx + 1'b1 : idx;
            if (state == S_SAMPLE)
                for (int c = 0; c < CHANNELS; c++) shift[c][idx] <= ~sync2[c];
            ready    <= state == S_DONE;
            pressed  <= state == S_DONE ? new_btn & ~buttons : '0;
            released <= state == S_DONE ? buttons & ~new_btn : '0;
            if (state == S_DONE) begin
                buttons <= new_btn;
                present <= det;
            end
        end
    end
endmodule

// File: tb/tb_pad_array_reader.sv
// tb_pad_array_reader: directed checks of a two-pad NES reader and a one-pad SNES reader
module tb_pad_array_reader;
    logic        clk = 1'b0;
    logic        reset, enable, poll_req, en_s, poll_s;
    logic        pad_latch, pad_clk, ready, pad_latch_s, pad_clk_s, ready_s;
    logic [1:0]  pad_data, present;
    logic [0:0]  pad_data_s, present_s;
    logic [15:0] buttons, pressed, released, buttons_s, pressed_s, released_s;
    logic [7:0]  btn0, btn1;
    logic [15:0] btn_s;
    logic [15:0] sr0 = '1, sr1 = '1, sr_s = '1;
    logic        pclk_q = 1'b0, pclk_s_q = 1'b0, float1, p;
    int          checks = 0, errors = 0;
    int          n, k, pulses, bad, hi, lo, rises, readys;

    always #5 clk = ~clk;

    pad_array_reader #(.BOARD(1_000_000), .SAMPLE(10_000), .LATCH(12), .CLK(6),
                       .CHANNELS(2), .BITS(8)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .poll_req(poll_req),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .pad_data(pad_data),
        .buttons(buttons), .pressed(pressed), .released(released),
        .present(present), .ready(ready)
    );

    pad_array_reader #(.BOARD(1_000_000), .SAMPLE(10_000), .LATCH(12), .CLK(6),
                       .CHANNELS(1), .BITS(16)) u_snes (
        .clk(clk), .reset(reset), .enable(en_s), .poll_req(poll_s),
        .pad_latch(pad_latch_s), .pad_clk(pad_clk_s), .pad_data(pad_data_s),
        .buttons(buttons_s), .pressed(pressed_s), .released(released_s),
        .present(present_s), .ready(ready_s)
    );

    // Pads: parallel load while latched, shift on pad_clk rise, ground shifted in behind the buttons
    always @(posedge clk) begin
        if (pad_latch) begin
            sr0 <= {8'h00, ~btn0};
            sr1 <= {8'h00, ~btn1};
        end else if (pad_clk && !pclk_q) begin
            sr0 <= sr0 >> 1;
            sr1 <= sr1 >> 1;
        end
        pclk_q <= pad_clk;
        if (pad_latch_s) sr_s <= ~btn_s;
        else if (pad_clk_s && !pclk_s_q) sr_s <= sr_s >> 1;
        pclk_s_q <= pad_clk_s;
    end

    assign pad_data   = {float1 ? 1'b1 : sr1[0], sr0[0]};
    assign pad_data_s = sr_s[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poll();
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        n = 0;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, ready, 1);
    endtask

    task automatic wait_latch_rise(output int cnt);
        cnt = 0;
        p = pad_latch;
        while (cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (pad_latch && !p) break;
            p = pad_latch;
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; poll_req = 1'b0; en_s = 1'b0; poll_s = 1'b0;
        btn0 = 8'h09; btn1 = 8'h80; btn_s = 16'h0803; float1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_buttons", buttons, 0);
        chk("rst_pressed", pressed, 0);
        chk("rst_released", released, 0);
        chk("rst_present", present, 0);
        chk("rst_ready", ready, 0);
        chk("rst_latch", pad_latch, 0);
        chk("rst_padclk", pad_clk, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        poll();
        n = 1;
        while (!pad_latch && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("poll_to_latch_le2", n <= 2, 1);
        n = 0;
        while (pad_latch && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("latch_width", n, 12);
        pulses = 0; bad = 0; hi = 0; lo = 0; p = 1'b0; n = 0;
        // Low gap between pulses is CLK_LO plus the one-cycle SAMPLE state
        while (!ready && n < 200) begin
            if (pad_clk && !p) begin
                pulses++;
                if (pulses > 1 && lo != 4) bad++;
                hi = 0;
            end
            if (!pad_clk && p) begin
                if (hi != 3) bad++;
                lo = 0;
            end
            if (pad_clk) hi++; else lo++;
            p = pad_clk;
            @(negedge clk);
            n++;
        end
        chk("f1_ready", ready, 1);
        chk("f1_pulses", pulses, 8);
        chk("f1_pulse_shape", bad, 0);
        chk("f1_buttons", buttons, 16'h8009);
        chk("f1_present", present, 2'b11);
        chk("f1_pressed", pressed, 16'h8009);
        chk("f1_released", released, 0);
        @(negedge clk);
        chk("f1_ready_drop", ready, 0);
        chk("f1_pressed_drop", pressed, 0);
        chk("f1_buttons_hold", buttons, 16'h8009);

        btn0 = 8'h0C;
        poll();
        wait_ready("f2_ready");
        chk("f2_pressed", pressed, 16'h0004);
        chk("f2_released", released, 16'h0001);
        chk("f2_buttons", buttons, 16'h800C);

        float1 = 1'b1;
        poll();
        wait_ready("f3_ready");
        chk("f3_present", present, 2'b01);
        chk("f3_buttons", buttons, 16'h000C);
        chk("f3_released", released, 16'h8000);
        chk("f3_pressed", pressed, 0);
        poll();
        wait_ready("f4_ready");
        chk("f4_present", present, 2'b01);
        chk("f4_buttons", buttons, 16'h000C);
        chk("f4_pressed", pressed, 0);
        chk("f4_released", released, 0);

        @(negedge clk);
        rises = 0; readys = 0; p = pad_latch;
        for (int i = 0; i < 250; i++) begin
            poll_req = (i == 0 || i == 20 || i == 30 || i == 40);
            @(negedge clk);
            if (pad_latch && !p) rises++;
            if (ready) readys++;
            p = pad_latch;
        end
        poll_req = 1'b0;
        chk("collapse_frames", rises, 2);
        chk("collapse_readys", readys, 2);

        enable = 1'b1;
        wait_latch_rise(n);
        chk("per_first_seen", n < 400, 1);
        wait_latch_rise(n);
        chk("per_interval1", n, 100);
        wait_latch_rise(n);
        chk("per_interval2", n, 100);

        n = 0; k = 0; p = pad_clk;
        while (k < 5 && n < 200) begin
            @(negedge clk);
            n++;
            if (pad_clk && !p) k++;
            p = pad_clk;
        end
        chk("bit4_clk_hi", {k[7:0], pad_clk}, {8'd5, 1'b1});
        reset = 1'b0;
        #1;
        chk("ar_padclk", pad_clk, 0);
        chk("ar_latch", pad_latch, 0);
        chk("ar_buttons", buttons, 0);
        chk("ar_present", present, 0);
        chk("ar_ready", ready, 0);
        chk("ar_pressed", pressed, 0);
        chk("ar_released", released, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_latch_rise(n);
        chk("ar_first_latch", n >= 100 && n <= 102, 1);

        enable = 1'b0;
        poll_s = 1'b1;
        @(negedge clk);
        poll_s = 1'b0;
        pulses = 0; n = 0; p = pad_clk_s;
        while (!ready_s && n < 400) begin
            @(negedge clk);
            n++;
            if (pad_clk_s && !p) pulses++;
            p = pad_clk_s;
        end
        chk("snes_ready", ready_s, 1);
        chk("snes_pulses", pulses, 16);
        chk("snes_buttons", buttons_s, 16'h0803);
        chk("snes_present", present_s, 1);
        chk("snes_pressed", pressed_s, 16'h0803);
        @(negedge clk);
        chk("snes_ready_drop", ready_s, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
